// File: rtl/lsu_byte_lane_unit_pkg.sv
// Shared types and helpers for the load/store byte-lane unit.
// Used with or without LSU_MISALIGN_TRAP_EN.
package lsu_byte_lane_unit_pkg;

   localparam logic [2:0] LSU_F3_B  = 3'd0;
   localparam logic [2:0] LSU_F3_H  = 3'd1;
   localparam logic [2:0] LSU_F3_W  = 3'd2;
   localparam logic [2:0] LSU_F3_BU = 3'd4;
   localparam logic [2:0] LSU_F3_HU = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } lsu_state_e;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } lsu_size_e;

   // Unsigned variants only exist for loads; unknown codes fall back to a word.
   function automatic lsu_size_e access_size(input logic [2:0] f3, input logic wr);
      case (f3)
         LSU_F3_B:  return SZ_B;
         LSU_F3_H:  return SZ_H;
         LSU_F3_BU: return wr ? SZ_W : SZ_B;
         LSU_F3_HU: return wr ? SZ_W : SZ_H;
         default:   return SZ_W;
      endcase
   endfunction

   function automatic logic is_misaligned(input lsu_size_e sz, input logic [1:0] lo);
      case (sz)
         SZ_H:    return lo[0];
         SZ_W:    return |lo;
         default: return 1'b0;
      endcase
   endfunction

   // Natural alignment of the low address bits for the access size.
   function automatic logic [1:0] align_low(input lsu_size_e sz, input logic [1:0] lo);
      case (sz)
         SZ_B:    return lo;
         SZ_H:    return {lo[1], 1'b0};
         default: return 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data aligner: selects the addressed byte/half of the returned word
// and sign- or zero-extends it according to funct3.
module lsu_load_align
   import lsu_byte_lane_unit_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Lane extraction followed by extension.
   always_comb begin
      byte_v = word[{addr_lo, 3'b000} +: 8];
      half_v = word[{addr_lo[1], 4'b0000} +: 16];
      case (funct3)
         LSU_F3_B:  result = {{24{byte_v[7]}}, byte_v};
         LSU_F3_H:  result = {{16{half_v[15]}}, half_v};
         LSU_F3_BU: result = {24'd0, byte_v};
         LSU_F3_HU: result = {16'd0, half_v};
         default:   result = word;
      endcase
   end

endmodule

// File: rtl/lsu_byte_lane_unit.sv
// Memory-stage load/store unit: builds store lanes, sequences one access
// at a time through the memory port and returns extended load data.
// Define LSU_MISALIGN_TRAP_EN to report misaligned accesses on
// rsp_misaligned instead of forcing natural alignment.
module lsu_byte_lane_unit
   import lsu_byte_lane_unit_pkg::*;
#(
   parameter int unsigned CORE         = 0,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ADDRESS_BITS = 32
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [2:0]              req_funct3,
   input  logic [ADDRESS_BITS-1:0] req_address,
   input  logic [DATA_WIDTH-1:0]   req_store_data,
   output logic                    mem_read,
   output logic                    mem_write,
   output logic [ADDRESS_BITS-3:0] mem_address,
   output logic [3:0]              mem_byte_en,
   output logic [DATA_WIDTH-1:0]   mem_write_data,
   input  logic                    mem_ready,
   input  logic                    mem_rsp_valid,
   input  logic [DATA_WIDTH-1:0]   mem_rsp_data,
   output logic                    rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_data
`ifdef LSU_MISALIGN_TRAP_EN
   ,
   output logic                    rsp_misaligned
`endif
);

   lsu_state_e              state_q, state_d;
   logic                    write_q, write_d;
   logic [2:0]              funct3_q, funct3_d;
   logic [ADDRESS_BITS-1:0] addr_q, addr_d;
   logic [3:0]              be_q, be_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
   logic                    mis_q, mis_d;
`endif
   lsu_size_e               size_c;
   logic [1:0]              low_c;
   logic [DATA_WIDTH-1:0]   load_ext;
   logic                    unused_core;

   assign unused_core = (CORE == 0);

   lsu_load_align u_load_align (
      .word    (mem_rsp_data),
      .addr_lo (addr_q[1:0]),
      .funct3  (funct3_q),
      .result  (load_ext)
   );

   // Next-state and capture logic; store lanes are built at accept time.
   always_comb begin
      state_d  = state_q;
      write_d  = write_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      be_d     = be_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_d    = mis_q;
`endif
      size_c   = access_size(req_funct3, req_write);
`ifdef LSU_MISALIGN_TRAP_EN
      low_c    = req_address[1:0];
`else
      low_c    = align_low(size_c, req_address[1:0]);
`endif
      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready) begin
               write_d  = req_write;
               funct3_d = req_funct3;
               addr_d   = {req_address[ADDRESS_BITS-1:2], low_c};
               rdata_d  = '0;
               case (size_c)
                  SZ_B: begin
                     be_d    = 4'b0001 << low_c;
                     wdata_d = {4{req_store_data[7:0]}};
                  end
                  SZ_H: begin
                     be_d    = 4'b0011 << {low_c[1], 1'b0};
                     wdata_d = {2{req_store_data[15:0]}};
                  end
                  default: begin
                     be_d    = 4'b1111;
                     wdata_d = req_store_data;
                  end
               endcase
`ifdef LSU_MISALIGN_TRAP_EN
               mis_d   = is_misaligned(size_c, low_c);
               state_d = mis_d ? S_RESP : S_ISSUE;
`else
               state_d = S_ISSUE;
`endif
            end
         end
         S_ISSUE: begin
            if (mem_ready) state_d = write_q ? S_RESP : S_WAIT;
         end
         S_WAIT: begin
            if (mem_rsp_valid) begin
               rdata_d = load_ext;
               state_d = S_RESP;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and captured request registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         write_q  <= 1'b0;
         funct3_q <= '0;
         addr_q   <= '0;
         be_q     <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
         mis_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         write_q  <= write_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         be_q     <= be_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
         mis_q    <= mis_d;
`endif
      end
   end

   assign req_ready      = (state_q == S_IDLE) && !reset;
   assign mem_read       = (state_q == S_ISSUE) && !write_q;
   assign mem_write      = (state_q == S_ISSUE) && write_q;
   assign mem_address    = addr_q[ADDRESS_BITS-1:2];
   assign mem_byte_en    = be_q;
   assign mem_write_data = wdata_q;
   assign rsp_valid      = (state_q == S_RESP);
   assign rsp_data       = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
   assign rsp_misaligned = mis_q;
`endif

endmodule
